// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the Simplez memory arbiter.
//   MEM_AW / MEM_DW : default address and data widths (512 x 12 memory)
//   state_e         : arbiter FSM encoding (ST_IDLE = 0, ST_ACCESS = 1)
//   PORT_CPU/LDR    : requester indices (0 = CPU control unit, 1 = loader/debug)
// Configuration macro used by the importing files: MEM_ARB_LOADER_PRIO_EN.
package mem_arb_pkg;

  localparam int MEM_AW = 9;
  localparam int MEM_DW = 12;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection for mem_arbiter.
// Ports:
//   req0_i, req1_i : access requests from CPU (0) and loader (1)
//   last_i         : port granted last (round-robin build only)
//   valid_o        : at least one request present
//   port_o         : index of the winning port
// Macro MEM_ARB_LOADER_PRIO_EN: when defined the loader always wins a tie and
// no last-grant input exists; otherwise ties go to the port not granted last.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
`ifndef MEM_ARB_LOADER_PRIO_EN
  input  logic last_i,
`endif
  output logic valid_o,
  output logic port_o
);

  always_comb begin
    valid_o = req0_i | req1_i;
    port_o  = PORT_CPU;
    if (req0_i && req1_i) begin
`ifdef MEM_ARB_LOADER_PRIO_EN
      port_o = PORT_LDR;
`else
      // Tie: the port that did not win last time goes now.
      port_o = (last_i == PORT_CPU) ? PORT_LDR : PORT_CPU;
`endif
    end else if (req1_i) begin
      port_o = PORT_LDR;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port 512x12 Simplez memory between the CPU
// control unit (port 0) and the loader/debug port (port 1). Every access is a
// fixed two-cycle transaction: IDLE samples requests and registers the winner's
// address/strobe/data onto the memory bus, ACCESS lets the memory act on the
// negedge, and the following posedge returns data with a one-cycle ack.
// Ports:
//   clk_i, rst_i                     : clock, asynchronous active-high reset
//   reqN_i, addrN_i, wrN_i, wdataN_i : request side of port N (N = 0, 1)
//   ackN_o, rdataN_o                 : completion pulse and read data of port N
//   mem_addr_o, mem_wr_o, mem_wdata_o: registered memory controls
//   mem_rdata_i                      : memory data_out
// Macro MEM_ARB_LOADER_PRIO_EN: fixed loader priority instead of round-robin.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = MEM_AW,
  parameter int DW = MEM_DW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req0_i,
  input  logic [AW-1:0] addr0_i,
  input  logic          wr0_i,
  input  logic [DW-1:0] wdata0_i,
  input  logic          req1_i,
  input  logic [AW-1:0] addr1_i,
  input  logic          wr1_i,
  input  logic [DW-1:0] wdata1_i,
  output logic          ack0_o,
  output logic [DW-1:0] rdata0_o,
  output logic          ack1_o,
  output logic [DW-1:0] rdata1_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_wr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  state_e        state_q, state_d;
  logic          winner_q, winner_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_wr_q, mem_wr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic          grant_valid;
  logic          grant_port;
`ifndef MEM_ARB_LOADER_PRIO_EN
  logic          last_q, last_d;
`endif

  mem_arb_pick u_pick (
    .req0_i  (req0_i),
    .req1_i  (req1_i),
`ifndef MEM_ARB_LOADER_PRIO_EN
    .last_i  (last_q),
`endif
    .valid_o (grant_valid),
    .port_o  (grant_port)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: ACCESS always lasts exactly one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (grant_valid) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values. Requests are only looked at in IDLE, so
  // anything a master changes during ACCESS has no effect on the transaction.
  always_comb begin
    winner_d    = winner_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_d    = 1'b0;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
`ifndef MEM_ARB_LOADER_PRIO_EN
    last_d      = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          winner_d    = grant_port;
          mem_addr_d  = (grant_port == PORT_LDR) ? addr1_i  : addr0_i;
          mem_wr_d    = (grant_port == PORT_LDR) ? wr1_i    : wr0_i;
          mem_wdata_d = (grant_port == PORT_LDR) ? wdata1_i : wdata0_i;
`ifndef MEM_ARB_LOADER_PRIO_EN
          last_d      = grant_port;
`endif
        end
      end
      ST_ACCESS: begin
        // The memory already updated data_out on the negedge; for a write it
        // holds the word's previous contents.
        if (winner_q == PORT_LDR) begin
          ack1_d   = 1'b1;
          rdata1_d = mem_rdata_i;
        end else begin
          ack0_d   = 1'b1;
          rdata0_d = mem_rdata_i;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset drops mem_wr at once so an in-flight write is
  // cancelled if it has not reached the memory's negedge yet.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      winner_q    <= PORT_CPU;
      mem_addr_q  <= '0;
      mem_wr_q    <= 1'b0;
      mem_wdata_q <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
`ifndef MEM_ARB_LOADER_PRIO_EN
      last_q      <= PORT_LDR;
`endif
    end else begin
      winner_q    <= winner_d;
      mem_addr_q  <= mem_addr_d;
      mem_wr_q    <= mem_wr_d;
      mem_wdata_q <= mem_wdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
`ifndef MEM_ARB_LOADER_PRIO_EN
      last_q      <= last_d;
`endif
    end
  end

  assign ack0_o      = ack0_q;
  assign ack1_o      = ack1_q;
  assign rdata0_o    = rdata0_q;
  assign rdata1_o    = rdata1_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule
